// File: rtl/inst_ram_loader.sv
// Boot loader: takes a length-prefixed little-endian byte stream, writes the
// assembled 32-bit words into instruction RAM, and holds the core in reset until the image is complete.
module inst_ram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        restart,
  output logic        inst_ram_wen,
  output logic [31:0] inst_ram_waddr,
  output logic [31:0] inst_ram_wdata,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned CNT_W       = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);
  localparam logic [31:0] STEP_W      = 32'(ADDR_STEP);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        asm_q, asm_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic               in_ready_q, in_ready_d;
  logic               wen_q, wen_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               load_done_q, load_done_d;
  logic               load_err_q, load_err_d;

  logic               accept_s;
  logic               last_byte_s;
  logic [31:0]        asm_next_s;
  logic [CNT_W-1:0]   word_cnt_inc_s;

  // Bytes enter at the top so the first byte of a word ends up in bits [7:0].
  assign accept_s       = in_valid && in_ready_q;
  assign last_byte_s    = (byte_cnt_q == 2'd3);
  assign asm_next_s     = {in_data, asm_q[31:8]};
  assign word_cnt_inc_s = word_cnt_q + CNT_W'(1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    addr_d       = addr_q;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    core_rst_n_d = core_rst_n_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;

    case (state_q)
      S_HDR: begin
        if (accept_s) begin
          asm_d      = asm_next_s;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte_s) begin
            // Full 32-bit compare so high garbage bits cannot alias a small count.
            if ((asm_next_s == 32'd0) || (asm_next_s > MAX_WORDS_W)) begin
              state_d    = S_ERR;
              load_err_d = 1'b1;
            end else begin
              state_d    = S_DATA;
              n_d        = asm_next_s[CNT_W-1:0];
              addr_d     = BASE_ADDR;
              word_cnt_d = '0;
              asm_d      = 32'd0;
            end
          end else begin
            state_d = S_HDR;
          end
        end else begin
          state_d = S_HDR;
        end
      end

      S_DATA: begin
        if (accept_s) begin
          asm_d      = asm_next_s;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (last_byte_s) begin
            state_d = S_WRITE;
            wen_d   = 1'b1;
            waddr_d = addr_q;
            wdata_d = asm_next_s;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_WRITE: begin
        addr_d     = addr_q + STEP_W;
        word_cnt_d = word_cnt_inc_s;
        if (word_cnt_inc_s == n_q) begin
          state_d      = S_DONE;
          core_rst_n_d = 1'b1;
          load_done_d  = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end

      S_DONE, S_ERR: begin
        if (restart) begin
          state_d      = S_HDR;
          byte_cnt_d   = 2'd0;
          word_cnt_d   = '0;
          asm_d        = 32'd0;
          core_rst_n_d = 1'b0;
          load_done_d  = 1'b0;
          load_err_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d      = S_HDR;
        byte_cnt_d   = 2'd0;
        word_cnt_d   = '0;
        asm_d        = 32'd0;
        core_rst_n_d = 1'b0;
        load_done_d  = 1'b0;
        load_err_d   = 1'b0;
      end
    endcase

    in_ready_d = (state_d == S_HDR) || (state_d == S_DATA);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 32'd0;
      n_q          <= '0;
      word_cnt_q   <= '0;
      addr_q       <= 32'd0;
      in_ready_q   <= 1'b1;
      wen_q        <= 1'b0;
      waddr_q      <= 32'd0;
      wdata_q      <= 32'd0;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      addr_q       <= addr_d;
      in_ready_q   <= in_ready_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign inst_ram_wen   = wen_q;
  assign inst_ram_waddr = waddr_q;
  assign inst_ram_wdata = wdata_q;
  assign core_rst_n     = core_rst_n_q;
  assign load_done      = load_done_q;
  assign load_err       = load_err_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader: a default instance and a BASE_ADDR=0x100,
// ADDR_STEP=1 instance share one byte stream; RAM writes are scoreboarded.
module tb_inst_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        restart;

  logic        in_ready_a, wen_a, core_rst_n_a, load_done_a, load_err_a;
  logic [31:0] waddr_a, wdata_a;
  logic        in_ready_b, wen_b, core_rst_n_b, load_done_b, load_err_b;
  logic [31:0] waddr_b, wdata_b;

  inst_ram_loader dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .restart(restart), .inst_ram_wen(wen_a),
    .inst_ram_waddr(waddr_a), .inst_ram_wdata(wdata_a),
    .core_rst_n(core_rst_n_a), .load_done(load_done_a), .load_err(load_err_a)
  );

  inst_ram_loader #(.BASE_ADDR(32'h0000_0100), .ADDR_STEP(1), .MAX_WORDS(1024)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .restart(restart), .inst_ram_wen(wen_b),
    .inst_ram_waddr(waddr_b), .inst_ram_wdata(wdata_b),
    .core_rst_n(core_rst_n_b), .load_done(load_done_b), .load_err(load_err_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int gap_max  = 0;

  logic [31:0] wa_a[$], wd_a[$], wa_b[$], wd_b[$];
  logic [31:0] exp_d[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Capture RAM writes away from the active edge; in_ready must be low while writing.
  always @(negedge clk) begin
    if (wen_a) begin
      wa_a.push_back(waddr_a);
      wd_a.push_back(wdata_a);
      check("ready_low_in_write", {31'd0, in_ready_a}, 32'd0);
    end
    if (wen_b) begin
      wa_b.push_back(waddr_b);
      wd_b.push_back(wdata_b);
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int t;
    int g;
    g = $urandom_range(0, gap_max);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", (t < 20) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("rst_wen", {31'd0, wen_a}, 32'd0);
    check("rst_waddr", waddr_a, 32'd0);
    check("rst_wdata", wdata_a, 32'd0);
    check("rst_core_rst_n", {31'd0, core_rst_n_a}, 32'd0);
    check("rst_load_done", {31'd0, load_done_a}, 32'd0);
    check("rst_load_err", {31'd0, load_err_a}, 32'd0);
  endtask

  // Entered at the negedge of the final WRITE cycle.
  task automatic check_done();
    check("last_wen", {31'd0, wen_a}, 32'd1);
    check("core_rst_n_in_last_write", {31'd0, core_rst_n_a}, 32'd0);
    @(negedge clk);
    check("core_rst_n_after", {31'd0, core_rst_n_a}, 32'd1);
    check("load_done_after", {31'd0, load_done_a}, 32'd1);
    check("in_ready_done", {31'd0, in_ready_a}, 32'd0);
    check("b_load_done_after", {31'd0, load_done_b}, 32'd1);
  endtask

  task automatic expect_writes();
    check("nwrites_a", 32'(wa_a.size()), 32'(exp_d.size()));
    check("nwrites_b", 32'(wa_b.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < wa_a.size()) begin
        check("waddr_a", wa_a[i], 32'(i) * 32'd4);
        check("wdata_a", wd_a[i], exp_d[i]);
      end
      if (i < wa_b.size()) begin
        check("waddr_b", wa_b[i], 32'h0000_0100 + 32'(i));
        check("wdata_b", wd_b[i], exp_d[i]);
      end
    end
    wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete(); exp_d.delete();
  endtask

  task automatic send_nominal_bytes();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h05); send_byte(8'h20); send_byte(8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    restart  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal two-word image, back-to-back bytes
    send_nominal_bytes();
    check_done();
    exp_d = '{32'h0010_0513, 32'h0020_0593};
    expect_writes();

    // Bytes offered in DONE without restart must be refused
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin
      check("ready_in_done_hold", {31'd0, in_ready_a}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("nwrites_in_done", 32'(wa_a.size()), 32'd0);

    pulse_restart();
    check("restart_core_rst_n", {31'd0, core_rst_n_a}, 32'd0);
    check("restart_load_done", {31'd0, load_done_a}, 32'd0);
    check("restart_in_ready", {31'd0, in_ready_a}, 32'd1);

    // Three-word reload with random gaps
    gap_max = 3;
    send_word(32'd3);
    send_word(32'h1122_3344);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0000_0013);
    check_done();
    exp_d = '{32'h1122_3344, 32'hDEAD_BEEF, 32'h0000_0013};
    expect_writes();

    // Nominal image again with gaps
    pulse_restart();
    gap_max = 2;
    send_nominal_bytes();
    check_done();
    exp_d = '{32'h0010_0513, 32'h0020_0593};
    expect_writes();
    gap_max = 0;

    // Header count 0
    pulse_restart();
    send_word(32'd0);
    check("err_zero", {31'd0, load_err_a}, 32'd1);
    check("err_zero_core_rst_n", {31'd0, core_rst_n_a}, 32'd0);
    check("err_zero_in_ready", {31'd0, in_ready_a}, 32'd0);
    repeat (2) @(negedge clk);
    check("err_zero_nwrites", 32'(wa_a.size()), 32'd0);

    // Header MAX_WORDS+1
    pulse_restart();
    check("err_cleared_1", {31'd0, load_err_a}, 32'd0);
    send_word(32'h0000_0401);
    check("err_max_plus_1", {31'd0, load_err_a}, 32'd1);

    // Header with high bits set must not alias a small count
    pulse_restart();
    send_word(32'h0001_0001);
    check("err_high_bits", {31'd0, load_err_a}, 32'd1);

    // Recovery with a valid one-word image
    pulse_restart();
    check("err_cleared_2", {31'd0, load_err_a}, 32'd0);
    check("err_cleared_in_ready", {31'd0, in_ready_a}, 32'd1);
    send_word(32'd1);
    send_word(32'h1234_5678);
    check_done();
    check("recovered_no_err", {31'd0, load_err_a}, 32'd0);
    exp_d = '{32'h1234_5678};
    expect_writes();

    // Asynchronous reset after two payload bytes
    pulse_restart();
    send_word(32'd2);
    send_byte(8'h13);
    send_byte(8'h05);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_nwrites", 32'(wa_a.size()), 32'd0);
    send_word(32'd2);
    send_word(32'h0010_0513);
    send_word(32'h0020_0593);
    check_done();
    exp_d = '{32'h0010_0513, 32'h0020_0593};
    expect_writes();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
